// File: rtl/rv_imm_pkg.sv
// Shared RISC-V decode constants and the immediate-format encoding used by the
// decode pipeline.
package rv_imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6
    } imm_fmt_t;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_SRLI = 3'b101;
    localparam logic [2:0] F3_SRAI = 3'b101;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction: instruction word -> {imm, fmt, illegal}.
module imm_decode
    import rv_imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    logic [6:0]        opc;
    logic [2:0]        f3;
    logic              is_shift;
    logic signed [31:0] raw;
    logic [5:0]        shamt;
    logic              use_shamt;

    always_comb begin
        opc       = inst[6:0];
        f3        = inst[14:12];
        is_shift  = (f3 == F3_SLLI) || (f3 == F3_SRLI) || (f3 == F3_SRAI);
        raw       = '0;
        shamt     = '0;
        use_shamt = 1'b0;
        fmt       = FMT_NONE;
        illegal   = 1'b0;

        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                raw = {inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt = FMT_J;
                raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD: begin
                fmt = FMT_I;
                raw = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPC_STORE: begin
                fmt = FMT_S;
                raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_OPIMM: begin
                if (is_shift) begin
                    fmt       = FMT_SH;
                    use_shamt = 1'b1;
                    shamt     = (XLEN == 64) ? inst[25:20] : {1'b0, inst[24:20]};
                end else begin
                    fmt = FMT_I;
                    raw = {{20{inst[31]}}, inst[31:20]};
                end
            end
            OPC_OPIMM32: begin
                // Word-sized ops only exist on RV64; their shifts are always 5-bit.
                if (XLEN == 64) begin
                    if (is_shift) begin
                        fmt       = FMT_SH;
                        use_shamt = 1'b1;
                        shamt     = {1'b0, inst[24:20]};
                    end else begin
                        fmt = FMT_I;
                        raw = {{20{inst[31]}}, inst[31:20]};
                    end
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP, OPC_MISCMEM, OPC_SYSTEM: begin
                fmt = FMT_NONE;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase

        imm = use_shamt ? XLEN'(shamt) : XLEN'(raw);
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a two-entry skid buffer so that
// in_ready comes straight from a flop; also counts illegal beats for debug.
module imm_gen_stage
    import rv_imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [PC_W-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst    (in_inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    logic             m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic [31:0]      m_inst_q, m_inst_d, s_inst_q, s_inst_d;
    logic [PC_W-1:0]  m_pc_q, m_pc_d, s_pc_q, s_pc_d;
    logic [XLEN-1:0]  m_imm_q, m_imm_d, s_imm_q, s_imm_d;
    logic [2:0]       m_fmt_q, m_fmt_d, s_fmt_q, s_fmt_d;
    logic             m_ill_q, m_ill_d, s_ill_q, s_ill_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             m_free;

    always_comb begin
        m_valid_d = m_valid_q;
        m_inst_d  = m_inst_q;
        m_pc_d    = m_pc_q;
        m_imm_d   = m_imm_q;
        m_fmt_d   = m_fmt_q;
        m_ill_d   = m_ill_q;
        s_valid_d = s_valid_q;
        s_inst_d  = s_inst_q;
        s_pc_d    = s_pc_q;
        s_imm_d   = s_imm_q;
        s_fmt_d   = s_fmt_q;
        s_ill_d   = s_ill_q;
        cnt_d     = cnt_q;

        accept = in_valid && in_ready_q;
        m_free = !m_valid_q || out_ready;

        if (m_free) begin
            if (s_valid_q) begin
                // Older skid beat always goes to M first to keep order.
                m_valid_d = 1'b1;
                m_inst_d  = s_inst_q;
                m_pc_d    = s_pc_q;
                m_imm_d   = s_imm_q;
                m_fmt_d   = s_fmt_q;
                m_ill_d   = s_ill_q;
                s_valid_d = accept;
                if (accept) begin
                    s_inst_d = in_inst;
                    s_pc_d   = in_pc;
                    s_imm_d  = dec_imm;
                    s_fmt_d  = dec_fmt;
                    s_ill_d  = dec_illegal;
                end
            end else begin
                m_valid_d = accept;
                if (accept) begin
                    m_inst_d = in_inst;
                    m_pc_d   = in_pc;
                    m_imm_d  = dec_imm;
                    m_fmt_d  = dec_fmt;
                    m_ill_d  = dec_illegal;
                end
            end
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_inst_d  = in_inst;
            s_pc_d    = in_pc;
            s_imm_d   = dec_imm;
            s_fmt_d   = dec_fmt;
            s_ill_d   = dec_illegal;
        end

        in_ready_d = !s_valid_d;

        if (accept && dec_illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q  <= 1'b0;
            m_inst_q   <= '0;
            m_pc_q     <= '0;
            m_imm_q    <= '0;
            m_fmt_q    <= '0;
            m_ill_q    <= 1'b0;
            s_valid_q  <= 1'b0;
            s_inst_q   <= '0;
            s_pc_q     <= '0;
            s_imm_q    <= '0;
            s_fmt_q    <= '0;
            s_ill_q    <= 1'b0;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            m_valid_q  <= m_valid_d;
            m_inst_q   <= m_inst_d;
            m_pc_q     <= m_pc_d;
            m_imm_q    <= m_imm_d;
            m_fmt_q    <= m_fmt_d;
            m_ill_q    <= m_ill_d;
            s_valid_q  <= s_valid_d;
            s_inst_q   <= s_inst_d;
            s_pc_q     <= s_pc_d;
            s_imm_q    <= s_imm_d;
            s_fmt_q    <= s_fmt_d;
            s_ill_q    <= s_ill_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    // A beat sitting in M is not offered downstream while reset is asserted.
    assign out_valid   = m_valid_q && !rst;
    assign in_ready    = in_ready_q;
    assign out_inst    = m_inst_q;
    assign out_pc      = m_pc_q;
    assign out_imm     = m_imm_q;
    assign out_fmt     = m_fmt_q;
    assign out_illegal = m_ill_q;
    assign illegal_cnt = cnt_q;

endmodule
